// File: rtl/led_status_pkg.sv
// led_status_pkg: shared per-unit state encoding and state-to-colour decode
package led_status_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    IFM  = 3'd1,
    FIM  = 3'd2,
    BDM  = 3'd3,
    END  = 3'd4
  } state_t;
  function automatic logic [2:0] colour(state_t s, logic phase);
    return s == IFM ? 3'b100 :
           s == FIM ? 3'b001 :
           s == BDM ? 3'b010 :
           s == END ? {1'b0, phase, 1'b0} : 3'b000;
  endfunction
endpackage

// File: rtl/led_unit_fsm.sv
// led_unit_fsm: one unit's message-tracking state machine with registered {r,g,b} colour
module led_unit_fsm
  import led_status_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ifm,
  input  logic fim,
  input  logic bdm,
  input  logic stop,
  input  logic blink_phase,
  output logic r,
  output logic g,
  output logic b,
  output logic is_end
);
  state_t state, nxt;
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : nxt;
    {r, g, b} <= rst ? 3'b000 : colour(nxt, blink_phase);
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = ifm ? IFM : stop ? END : IDLE;
      IFM:     nxt = fim ? FIM : IFM;
      FIM:     nxt = bdm ? BDM : FIM;
      BDM:     nxt = fim ? FIM : stop ? END : BDM;
      default: nxt = END;
    endcase
  end
  assign is_end = state == END;
endmodule

// File: rtl/led_status_array.sv
// led_status_array: NUM_UNITS status LEDs sharing one phase-aligned blink generator.
// LED_STATUS_PWM_EN adds an 8-bit PWM dimmer on the led_* outputs (PWM_DUTY).
module led_status_array
  import led_status_pkg::*;
#(
  parameter int NUM_UNITS = 3,
  parameter int BLINK_DIV = 3125000,
  parameter int CNT_W     = 22
`ifdef LED_STATUS_PWM_EN
  ,parameter int PWM_DUTY = 128
`endif
)(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_UNITS-1:0] ifm,
  input  logic [NUM_UNITS-1:0] fim,
  input  logic                 bdm,
  input  logic                 stop,
  output logic [NUM_UNITS-1:0] led_r,
  output logic [NUM_UNITS-1:0] led_g,
  output logic [NUM_UNITS-1:0] led_b,
  output logic                 any_blue,
  output logic                 all_end
);
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic phase, phase_nxt, wrap, any_end;
  logic [NUM_UNITS-1:0] r, g, b, e;
  // Units are fed the phase the generator will hold after this edge so their
  // registered green always matches the shared phase register.
  always_comb begin
    wrap      = cnt == CNT_W'(BLINK_DIV - 1);
    cnt_nxt   = !any_end || wrap ? '0 : cnt + CNT_W'(1);
    phase_nxt = !any_end ? 1'b1 : wrap ? ~phase : phase;
  end
  always_ff @(posedge clock) begin
    cnt   <= reset ? '0 : cnt_nxt;
    phase <= reset ? 1'b1 : phase_nxt;
  end
  for (genvar i = 0; i < NUM_UNITS; i++) begin : g_unit
    led_unit_fsm u_fsm (
      .clk(clock), .rst(reset), .ifm(ifm[i]), .fim(fim[i]), .bdm(bdm), .stop(stop),
      .blink_phase(phase_nxt), .r(r[i]), .g(g[i]), .b(b[i]), .is_end(e[i])
    );
  end
  assign any_end  = |e;
  assign any_blue = |b;
  assign all_end  = &e;
`ifdef LED_STATUS_PWM_EN
  logic [7:0] pwm_cnt;
  logic pwm_on;
  always_ff @(posedge clock) pwm_cnt <= reset ? 8'd0 : pwm_cnt + 8'd1;
  assign pwm_on = pwm_cnt < 8'(PWM_DUTY);
  assign led_r = r & {NUM_UNITS{pwm_on}};
  assign led_g = g & {NUM_UNITS{pwm_on}};
  assign led_b = b & {NUM_UNITS{pwm_on}};
`else
  assign led_r = r;
  assign led_g = g;
  assign led_b = b;
`endif
endmodule

// File: tb/tb_led_status_array.sv
// tb_led_status_array: directed self-checking bench for led_status_array (3 units, BLINK_DIV=4)
module tb_led_status_array;
  logic clock = 0, reset = 1, bdm = 0, stop = 0;
  logic [2:0] ifm = 0, fim = 0, led_r, led_g, led_b;
  logic any_blue, all_end;
  int checks = 0, errors = 0;
  led_status_array #(.NUM_UNITS(3), .BLINK_DIV(4), .CNT_W(3)) dut (
    .clock(clock), .reset(reset), .ifm(ifm), .fim(fim), .bdm(bdm), .stop(stop),
    .led_r(led_r), .led_g(led_g), .led_b(led_b), .any_blue(any_blue), .all_end(all_end)
  );
  always #5 clock = ~clock;
  task automatic step();
    @(posedge clock);
    #1;
    ifm = 0; fim = 0; bdm = 0; stop = 0;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_all(input string tag, input logic [2:0] r, g, b, input logic ab, ae);
    chk({tag, "_r"}, 16'(led_r), 16'(r));
    chk({tag, "_g"}, 16'(led_g), 16'(g));
    chk({tag, "_b"}, 16'(led_b), 16'(b));
    chk({tag, "_any_blue"}, 16'(any_blue), 16'(ab));
    chk({tag, "_all_end"}, 16'(all_end), 16'(ae));
  endtask
  function automatic logic ph(input int k);
    return ((k / 4) % 2) == 0;
  endfunction
  initial begin
    step(); step();
    reset = 0;
    for (int i = 0; i < 10; i++) step();
    chk_all("idle", 3'b000, 3'b000, 3'b000, 0, 0);
    // unit 0 through red, blue, green
    ifm = 3'b001; step();
    chk_all("ifm", 3'b001, 3'b000, 3'b000, 0, 0);
    fim = 3'b001; step();
    chk_all("fim", 3'b000, 3'b000, 3'b001, 1, 0);
    bdm = 1; step();
    chk_all("bdm", 3'b000, 3'b001, 3'b000, 0, 0);
    // fim beats stop in BDM; idle units 1,2 take stop into END
    fim = 3'b001; stop = 1; step();
    chk_all("fim_stop", 3'b000, 3'b110, 3'b001, 1, 0);
    stop = 1; step();
    chk_all("fim_ignores_stop", 3'b000, 3'b110, 3'b001, 1, 0);
    // ifm beats stop in IDLE
    reset = 1; step(); reset = 0;
    ifm = 3'b100; stop = 1; step();
    chk_all("ifm_stop", 3'b100, 3'b011, 3'b000, 0, 0);
    // all units blink in lockstep
    reset = 1; step(); reset = 0;
    chk_all("reset2", 3'b000, 3'b000, 3'b000, 0, 0);
    stop = 1; step();
    for (int k = 0; k < 17; k++) begin
      chk($sformatf("blink_g_k%0d", k), 16'(led_g), ph(k) ? 16'h7 : 16'h0);
      chk("blink_all_end", 16'(all_end), 16'h1);
      step();
    end
    // reset while blinking, then normal operation
    reset = 1; step(); reset = 0;
    chk_all("reset_blink", 3'b000, 3'b000, 3'b000, 0, 0);
    step();
    chk_all("reset_hold", 3'b000, 3'b000, 3'b000, 0, 0);
    ifm = 3'b010; step();
    chk_all("ifm_after_reset", 3'b010, 3'b000, 3'b000, 0, 0);
    // late entrant adopts current phase: unit 0 END at k=0, unit 1 at k=6
    reset = 1; step(); reset = 0;
    ifm = 3'b110; step();
    stop = 1; step();
    chk_all("late_k0", 3'b110, 3'b001, 3'b000, 0, 0);
    step();
    fim = 3'b010; step();
    chk_all("late_fim", 3'b100, 3'b001, 3'b010, 1, 0);
    bdm = 1; step();
    chk_all("late_bdm", 3'b100, 3'b011, 3'b000, 0, 0);
    step(); step();
    stop = 1; step();
    for (int k = 6; k < 18; k++) begin
      chk($sformatf("late_g1_k%0d", k), 16'(led_g[1]), 16'(led_g[0]));
      chk($sformatf("late_g0_k%0d", k), 16'(led_g), ph(k) ? 16'h3 : 16'h0);
      chk("late_r", 16'(led_r), 16'h4);
      chk("late_all_end", 16'(all_end), 16'h0);
      step();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
